mips_top: RTL and testbench

//  Top level of a multicycle 32-bit MIPS subset CPU with one unified instruction/data memory.

---
 rtl/mips_top.sv | 123 ++++++++++++
 tb/tb_mips_top.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_top.sv
// mips_top: multicycle 32-bit MIPS subset CPU (add/sub/and/or/slt/lw/sw/beq/addi/j) with a unified RAM.
// Define MIPS_EXTOPS_EN to add bne, andi and ori.
module mips_top #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata,
    output logic [31:0] dataadr,
    output logic        memwrite,
    output logic [31:0] datapc,
    output logic [5:0]  pclow
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
                           S_BEQEX = 4'd8, S_ADDIEX = 4'd9, S_ADDIWB = 4'd10, S_JEX = 4'd11;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                           OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [2:0] A_AND = 3'd0, A_OR = 3'd1, A_ADD = 3'd2, A_SUB = 3'd6, A_SLT = 3'd7;

    logic [3:0]  state_q, state_d, dec_d;
    logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, mdr_q;
    logic [31:0] rf_q [32];
    logic [31:0] mem_q [MEM_WORDS];
    logic [5:0]  op, funct;
    logic [31:0] imm, alu_x, alu_y, alu_r, rs_v, rt_v;
    logic [2:0]  alu_op, f_op, i_op;
    logic [4:0]  rf_wa;
    logic        ext_op, is_bne, zero, rf_we;

    assign op    = ir_q[31:26];
    assign funct = ir_q[5:0];

`ifdef MIPS_EXTOPS_EN
    localparam logic [5:0] OP_BNE = 6'h05, OP_ANDI = 6'h0c, OP_ORI = 6'h0d;
    assign ext_op = op == OP_ANDI || op == OP_ORI;
    assign is_bne = op == OP_BNE;
    assign i_op   = op == OP_ANDI ? A_AND : op == OP_ORI ? A_OR : A_ADD;
    assign dec_d  = is_bne ? S_BEQEX : ext_op ? S_ADDIEX : S_FETCH;
`else
    assign ext_op = 1'b0;
    assign is_bne = 1'b0;
    assign i_op   = A_ADD;
    assign dec_d  = S_FETCH;
`endif

    always_comb begin
        imm     = ext_op ? {16'h0, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};
        rs_v    = ir_q[25:21] == 5'd0 ? 32'd0 : rf_q[ir_q[25:21]];
        rt_v    = ir_q[20:16] == 5'd0 ? 32'd0 : rf_q[ir_q[20:16]];
        alu_x   = state_q == S_FETCH || state_q == S_DECODE ? pc_q : a_q;
        alu_y   = state_q == S_FETCH ? 32'd4 :
                  state_q == S_DECODE ? {imm[29:0], 2'b00} :
                  state_q == S_MEMADR || state_q == S_ADDIEX ? imm : b_q;
        f_op    = funct == 6'h22 ? A_SUB : funct == 6'h24 ? A_AND :
                  funct == 6'h25 ? A_OR : funct == 6'h2a ? A_SLT : A_ADD;
        alu_op  = state_q == S_RTYPEEX ? f_op : state_q == S_ADDIEX ? i_op :
                  state_q == S_BEQEX ? A_SUB : A_ADD;
        alu_r   = alu_op == A_AND ? alu_x & alu_y :
                  alu_op == A_OR  ? alu_x | alu_y :
                  alu_op == A_SUB ? alu_x - alu_y :
                  alu_op == A_SLT ? {31'd0, $signed(alu_x) < $signed(alu_y)} : alu_x + alu_y;
        zero    = alu_r == 32'd0;
        state_d = state_q == S_FETCH ? S_DECODE :
                  state_q == S_DECODE ? (op == OP_R ? S_RTYPEEX :
                                         op == OP_LW || op == OP_SW ? S_MEMADR :
                                         op == OP_BEQ ? S_BEQEX :
                                         op == OP_ADDI ? S_ADDIEX :
                                         op == OP_J ? S_JEX : dec_d) :
                  state_q == S_MEMADR ? (op == OP_LW ? S_MEMRD : S_MEMWR) :
                  state_q == S_MEMRD ? S_MEMWB :
                  state_q == S_RTYPEEX ? S_RTYPEWB :
                  state_q == S_ADDIEX ? S_ADDIWB : S_FETCH;
        rf_we   = state_q == S_MEMWB || state_q == S_RTYPEWB || state_q == S_ADDIWB;
        rf_wa   = state_q == S_RTYPEWB ? ir_q[15:11] : ir_q[20:16];
    end

    assign memwrite  = state_q == S_MEMWR;
    assign dataadr   = state_q == S_MEMRD || state_q == S_MEMWR ? aluout_q : pc_q;
    assign writedata = b_q;
    assign datapc    = ir_q;
    assign pclow     = pc_q[7:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                ir_q <= mem_q[pc_q[AW+1:2]];
                pc_q <= alu_r;
            end
            if (state_q == S_DECODE) begin
                a_q <= rs_v;
                b_q <= rt_v;
            end
            if (state_q == S_DECODE || state_q == S_MEMADR || state_q == S_RTYPEEX || state_q == S_ADDIEX)
                aluout_q <= alu_r;
            if (state_q == S_MEMRD)
                mdr_q <= mem_q[aluout_q[AW+1:2]];
            // bne shares BEQEX; only the sense of the zero flag differs
            if (state_q == S_BEQEX && (zero ^ is_bne))
                pc_q <= aluout_q;
            if (state_q == S_JEX)
                pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
        end
    end

    // Writes are suppressed while reset is high so an aborted instruction leaves no trace
    always_ff @(posedge clk) begin
        if (!reset && rf_we && rf_wa != 5'd0)
            rf_q[rf_wa] <= state_q == S_MEMWB ? mdr_q : aluout_q;
        if (!reset && memwrite)
            mem_q[aluout_q[AW+1:2]] <= b_q;
    end
endmodule

// File: tb/tb_mips_top.sv
// tb_mips_top: table of small programs with a store scoreboard, plus hand-timed reset, branch and lw sequences.
module tb_mips_top;
    localparam int NV = 14;
    typedef struct {
        int          n;
        logic [31:0] a0, d0, a1, d1;
    } vec_t;
    localparam logic [31:0] STD [19] = '{
        32'h20020005, 32'h2003000c, 32'h2067fff7, 32'h00e22025, 32'h00642824,
        32'h00a42820, 32'h10a7000a, 32'h0064202a, 32'h10800001, 32'h20050000,
        32'h00e2202a, 32'h00853820, 32'h00e23822, 32'hac670044, 32'h8c020050,
        32'h08000011, 32'h20020001, 32'hac020054, 32'h08000012};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] writedata, dataadr, datapc;
    logic        memwrite;
    logic [5:0]  pclow;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb [$];
    logic [31:0] img [20];
    logic [31:0] prog [NV][20];
    vec_t        vecs [NV];

    mips_top dut (
        .clk(clk), .reset(reset), .writedata(writedata), .dataadr(dataadr),
        .memwrite(memwrite), .datapc(datapc), .pclow(pclow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int f, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(f)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int w);
        return {6'h02, 26'(w)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (memwrite === 1'b1 && reset === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_store: got adr %h data %h, expected no store", dataadr, writedata);
            end else
                check("store {adr,data}", {dataadr, writedata}, sb.pop_front());
        end

    task automatic load();
        for (int k = 0; k < 64; k++)
            dut.mem_q[k] = (k < 20) ? img[k] : 32'h0;
    endtask

    task automatic start();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        load();
        #1 reset = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d stores outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        repeat (25) @(posedge clk);
    endtask

    initial begin
        for (int k = 0; k < 20; k++)
            img[k] = k < 19 ? STD[k] : 32'h0;
        load();
        #18;
        check("reset_pclow", pclow, 0);
        check("reset_memwrite", memwrite, 0);
        check("reset_datapc", datapc, 0);
        check("reset_dataadr", dataadr, 0);
        #4 reset = 1'b0;
        @(negedge clk);
        check("first_fetch_datapc", datapc, STD[0]);
        check("first_fetch_pclow", pclow, 1);

        for (int v = 0; v < NV; v++)
            for (int k = 0; k < 20; k++)
                prog[v][k] = 32'h0;
        for (int k = 0; k < 19; k++)
            prog[0][k] = STD[k];
        vecs[0] = '{2, 80, 7, 84, 7};
        prog[1][0] = enc_i(8, 2, 0, 5);       prog[1][1] = enc_i(43, 2, 0, 68);     prog[1][2] = enc_j(2);
        vecs[1] = '{1, 68, 5, 0, 0};
        prog[2][0] = enc_i(8, 1, 0, 7);       prog[2][1] = enc_i(8, 2, 0, 3);
        prog[2][2] = enc_r(32'h22, 3, 1, 2);  prog[2][3] = enc_i(43, 3, 0, 80);     prog[2][4] = enc_j(4);
        vecs[2] = '{1, 80, 4, 0, 0};
        prog[3][0] = enc_i(8, 1, 0, 12);      prog[3][1] = enc_i(8, 2, 0, 10);
        prog[3][2] = enc_r(32'h24, 3, 1, 2);  prog[3][3] = enc_i(43, 3, 0, 84);     prog[3][4] = enc_j(4);
        vecs[3] = '{1, 84, 8, 0, 0};
        prog[4][0] = enc_i(8, 1, 0, 12);      prog[4][1] = enc_i(8, 2, 0, 10);
        prog[4][2] = enc_r(32'h25, 3, 1, 2);  prog[4][3] = enc_i(43, 3, 0, 88);     prog[4][4] = enc_j(4);
        vecs[4] = '{1, 88, 14, 0, 0};
        prog[5][0] = enc_i(35, 1, 0, 76);     prog[5][1] = enc_i(8, 2, 0, 1);
        prog[5][2] = enc_r(32'h2a, 3, 1, 2);  prog[5][3] = enc_i(43, 3, 0, 92);     prog[5][4] = enc_j(4);
        prog[5][19] = 32'h80000000;
        vecs[5] = '{1, 92, 1, 0, 0};
        prog[6][0] = enc_i(35, 1, 0, 76);     prog[6][1] = enc_i(8, 2, 0, 1);
        prog[6][2] = enc_r(32'h2a, 3, 2, 1);  prog[6][3] = enc_i(43, 3, 0, 92);     prog[6][4] = enc_j(4);
        prog[6][19] = 32'h80000000;
        vecs[6] = '{1, 92, 0, 0, 0};
        prog[7][0] = enc_i(8, 1, 0, 5);       prog[7][1] = enc_r(32'h20, 0, 1, 1);
        prog[7][2] = enc_i(43, 0, 0, 96);     prog[7][3] = enc_j(3);
        vecs[7] = '{1, 96, 0, 0, 0};
        prog[8][0] = enc_i(8, 1, 0, -1);      prog[8][1] = enc_i(8, 2, 0, 2);
        prog[8][2] = enc_r(32'h20, 3, 1, 2);  prog[8][3] = enc_i(43, 3, 0, 100);    prog[8][4] = enc_j(4);
        vecs[8] = '{1, 100, 1, 0, 0};
        prog[9][0] = enc_i(8, 1, 0, 1);       prog[9][1] = enc_i(4, 0, 0, 1);
        prog[9][2] = enc_i(8, 1, 0, 9);       prog[9][3] = enc_i(43, 1, 0, 104);    prog[9][4] = enc_j(4);
        vecs[9] = '{1, 104, 1, 0, 0};
        prog[10][0] = enc_i(8, 1, 0, 1);      prog[10][1] = enc_i(4, 0, 1, 1);
        prog[10][2] = enc_i(8, 1, 0, 9);      prog[10][3] = enc_i(43, 1, 0, 104);   prog[10][4] = enc_j(4);
        vecs[10] = '{1, 104, 9, 0, 0};
        prog[11][0] = enc_i(8, 1, 0, 1);      prog[11][1] = enc_i(5, 0, 1, 1);
        prog[11][2] = enc_i(8, 1, 0, 9);      prog[11][3] = enc_i(43, 1, 0, 108);   prog[11][4] = enc_j(4);
        prog[12][0] = enc_i(8, 1, 0, -1);     prog[12][1] = enc_i(8, 2, 0, 3);      prog[12][2] = enc_i(8, 3, 0, 4);
        prog[12][3] = enc_i(12, 2, 1, 32'hf0f0); prog[12][4] = enc_i(13, 3, 0, 32'h8001);
        prog[12][5] = enc_i(43, 2, 0, 112);   prog[12][6] = enc_i(43, 3, 0, 116);   prog[12][7] = enc_j(7);
`ifdef MIPS_EXTOPS_EN
        vecs[11] = '{1, 108, 1, 0, 0};
        vecs[12] = '{2, 112, 32'h0000f0f0, 116, 32'h00008001};
`else
        vecs[11] = '{1, 108, 9, 0, 0};
        vecs[12] = '{2, 112, 3, 116, 4};
`endif
        prog[13][0] = enc_i(8, 1, 0, 1);      prog[13][1] = enc_j(3);               prog[13][2] = enc_i(8, 1, 0, 9);
        prog[13][3] = 32'hfc210005;           prog[13][4] = enc_i(43, 1, 0, 120);   prog[13][5] = enc_j(5);
        vecs[13] = '{1, 120, 1, 0, 0};

        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < 20; k++)
                img[k] = prog[v][k];
            start();
            sb.push_back({vecs[v].a0, vecs[v].d0});
            if (vecs[v].n > 1)
                sb.push_back({vecs[v].a1, vecs[v].d1});
            drain($sformatf("vec%0d", v));
            if (v == 1)
                check("sw_mem17", dut.mem_q[17], 5);
        end

        for (int k = 0; k < 20; k++)
            img[k] = 32'h0;
        img[0] = enc_i(8, 1, 0, 1);
        img[1] = enc_i(4, 0, 1, 5);
        img[2] = enc_i(4, 0, 0, -2);
        start();
        edges(7);
        check("beq_not_taken_pclow", pclow, 2);
        edges(1);
        check("beq_fetch_datapc", datapc, img[2]);
        edges(2);
        check("beq_taken_back_pclow", pclow, 1);

        img[0] = enc_i(35, 1, 0, 76);
        img[1] = enc_j(1);
        img[2] = 32'h0;
        img[19] = 32'h12345678;
        start();
        edges(3);
        check("lw_memrd_dataadr", dataadr, 76);
        edges(2);
        check("lw_5cycle_pclow", pclow, 1);
        check("lw_fetch_dataadr", dataadr, 4);
        edges(1);
        check("j_after_lw_datapc", datapc, enc_j(1));

        img[0] = enc_i(8, 1, 0, 5);
        img[1] = enc_i(43, 1, 0, 100);
        img[2] = enc_j(2);
        img[19] = 32'h0;
        start();
        edges(6);
        reset = 1'b1;
        edges(1);
        check("abort_memadr_pclow", pclow, 0);
        check("abort_memadr_memwrite", memwrite, 0);
        edges(1);
        check("abort_memadr_mem25", dut.mem_q[25], 0);
        sb.push_back({32'd100, 32'd5});
        reset = 1'b0;
        drain("restart_store");

        img[1] = enc_i(43, 1, 0, 104);
        start();
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        edges(1);
        check("abort_memwr_mem26", dut.mem_q[26], 0);
        check("abort_memwr_pclow", pclow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
